// File: rtl/alu_pkg.sv
// Shared definitions for the sequential MIPS ALU: opcode encodings,
// controller state encoding and a helper that classifies iterative ops.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_SLL   = 4'd4;
    localparam logic [3:0] ALU_SRL   = 4'd5;
    localparam logic [3:0] ALU_SLT   = 4'd6;
    localparam logic [3:0] ALU_SLTU  = 4'd7;
    localparam logic [3:0] ALU_NOR   = 4'd8;
    localparam logic [3:0] ALU_MULTU = 4'd9;
    localparam logic [3:0] ALU_DIVU  = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Multiply and divide take the multi-cycle path; everything else
    // (including the illegal opcodes) finishes in a single cycle.
    function automatic logic is_iterative(input logic [3:0] op);
        return (op == ALU_MULTU) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply/divide engine. One shift-add (multiply) or
// restoring shift-subtract (divide) step per cycle, WIDTH steps per op.
// The high word lives in acc_q, the low word in lo_q; hi_next/lo_next
// expose the result of the current step so the caller can capture the
// final values on the same edge that performs the last step.
module seq_alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             fin,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mode_q, mode_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] hi_step;
    logic [WIDTH-1:0] lo_step;

    // One datapath step: multiply shifts {acc,lo} right after a conditional
    // add; divide shifts {acc,lo} left and keeps the trial difference only
    // when it did not borrow. A zero divisor never borrows, which yields an
    // all-ones quotient and leaves the dividend as the remainder.
    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, b_q};
        rem_sh  = {acc_q, lo_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, b_q};
        hi_step = acc_q;
        lo_step = lo_q;
        if (mode_q) begin
            if (!diff[WIDTH]) begin
                hi_step = diff[WIDTH-1:0];
                lo_step = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_step = rem_sh[WIDTH-1:0];
                lo_step = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (lo_q[0]) begin
                {hi_step, lo_step} = {sum, lo_q[WIDTH-1:1]};
            end else begin
                {hi_step, lo_step} = {1'b0, acc_q, lo_q[WIDTH-1:1]};
            end
        end
    end

    // Load operands on go, otherwise advance one step while the counter runs.
    always_comb begin
        b_d    = b_q;
        acc_d  = acc_q;
        lo_d   = lo_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        if (go) begin
            b_d    = op_b;
            acc_d  = '0;
            lo_d   = op_a;
            cnt_d  = CW'(WIDTH);
            mode_d = div_mode;
        end else if (cnt_q != '0) begin
            acc_d = hi_step;
            lo_d  = lo_step;
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Engine registers; reset clears the counter so an aborted op stops.
    always_ff @(posedge clk) begin
        if (reset) begin
            b_q    <= '0;
            acc_q  <= '0;
            lo_q   <= '0;
            cnt_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            b_q    <= b_d;
            acc_q  <= acc_d;
            lo_q   <= lo_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    assign fin     = (cnt_q == CW'(1));
    assign hi_next = hi_step;
    assign lo_next = lo_step;

endmodule

// File: rtl/seq_alu.sv
// Handshaked MIPS ALU for the EX stage: single-cycle ops are computed
// combinationally and registered on acceptance, multu/divu are handed to
// the iterative engine. start/busy/done form the controller handshake.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic             zeroflag,
    output logic             divzero,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zf_q, zf_d;
    logic             dz_q, dz_d;
    logic             zf_pend_q, zf_pend_d;
    logic             dz_pend_q, dz_pend_d;
    logic             busy_q, done_q;

    logic [WIDTH-1:0] sc_res;
    logic             go;
    logic             div_mode;
    logic             eng_fin;
    logic [WIDTH-1:0] eng_hi;
    logic [WIDTH-1:0] eng_lo;

    seq_alu_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .go       (go),
        .div_mode (div_mode),
        .op_a     (in1),
        .op_b     (in2),
        .fin      (eng_fin),
        .hi_next  (eng_hi),
        .lo_next  (eng_lo)
    );

    // Single-cycle result; illegal opcodes and multu/divu produce zero here.
    always_comb begin
        sc_res = '0;
        case (aluop)
            ALU_ADD:  sc_res = in1 + in2;
            ALU_SUB:  sc_res = in1 - in2;
            ALU_AND:  sc_res = in1 & in2;
            ALU_OR:   sc_res = in1 | in2;
            ALU_SLL:  sc_res = in1 << in2[SHW-1:0];
            ALU_SRL:  sc_res = in1 >> in2[SHW-1:0];
            ALU_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            ALU_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            ALU_NOR:  sc_res = ~(in1 | in2);
            default:  sc_res = '0;
        endcase
    end

    // Controller next-state: accept in IDLE/FIN, wait for the engine in RUN.
    // Flags of an iterative op are parked until its result is published so
    // the visible outputs only ever change when entering FIN.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        hi_d      = hi_q;
        zf_d      = zf_q;
        dz_d      = dz_q;
        zf_pend_d = zf_pend_q;
        dz_pend_d = dz_pend_q;
        go        = 1'b0;
        div_mode  = (aluop == ALU_DIVU);
        case (state_q)
            RUN: begin
                if (eng_fin) begin
                    state_d = FIN;
                    out_d   = eng_lo;
                    hi_d    = eng_hi;
                    zf_d    = zf_pend_q;
                    dz_d    = dz_pend_q;
                end
            end
            default: begin
                if (start) begin
                    if (is_iterative(aluop)) begin
                        state_d   = RUN;
                        go        = 1'b1;
                        zf_pend_d = (in1 == in2);
                        dz_pend_d = (aluop == ALU_DIVU) && (in2 == '0);
                    end else begin
                        state_d = FIN;
                        out_d   = sc_res;
                        hi_d    = '0;
                        zf_d    = (in1 == in2);
                        dz_d    = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and registered outputs; busy/done are decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            out_q     <= '0;
            hi_q      <= '0;
            zf_q      <= 1'b0;
            dz_q      <= 1'b0;
            zf_pend_q <= 1'b0;
            dz_pend_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            hi_q      <= hi_d;
            zf_q      <= zf_d;
            dz_q      <= dz_d;
            zf_pend_q <= zf_pend_d;
            dz_pend_q <= dz_pend_d;
            busy_q    <= (state_d == RUN);
            done_q    <= (state_d == FIN);
        end
    end

    assign out      = out_q;
    assign hi       = hi_q;
    assign zeroflag = zf_q;
    assign divzero  = dz_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: expected results come from a behavioural
// model, are queued when an op is issued and compared when done pulses.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   aluop;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [W-1:0] out;
    logic [W-1:0] hi;
    logic         zeroflag;
    logic         divzero;
    logic         busy;
    logic         done;

    typedef struct {
        string        tag;
        logic [W-1:0] out;
        logic [W-1:0] hi;
        logic         zf;
        logic         dz;
        int           issue;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    seq_alu #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .aluop    (aluop),
        .in1      (in1),
        .in2      (in2),
        .out      (out),
        .hi       (hi),
        .zeroflag (zeroflag),
        .divzero  (divzero),
        .busy     (busy),
        .done     (done)
    );

    // Free-running clock and cycle counter used for latency checks
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference behaviour of one ALU operation
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [63:0]  p;
        logic [4:0]   sh;
        sh     = b[4:0];
        e.tag  = "";
        e.out  = '0;
        e.hi   = '0;
        e.zf   = (a == b);
        e.dz   = 1'b0;
        e.lat  = 1;
        e.issue = 0;
        case (op)
            ALU_ADD:  e.out = a + b;
            ALU_SUB:  e.out = a - b;
            ALU_AND:  e.out = a & b;
            ALU_OR:   e.out = a | b;
            ALU_SLL:  e.out = a << sh;
            ALU_SRL:  e.out = a >> sh;
            ALU_SLT:  e.out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: e.out = (a < b) ? 32'd1 : 32'd0;
            ALU_NOR:  e.out = ~(a | b);
            ALU_MULTU: begin
                p     = 64'(a) * 64'(b);
                e.out = p[31:0];
                e.hi  = p[63:32];
                e.lat = W + 1;
            end
            ALU_DIVU: begin
                e.lat = W + 1;
                if (b == 0) begin
                    e.out = '1;
                    e.hi  = a;
                    e.dz  = 1'b1;
                end else begin
                    e.out = a / b;
                    e.hi  = a % b;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    // Drive one request; optionally wait for the next falling edge first and
    // optionally queue the expected result
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input string tag, input bit sync, input bit expect_result);
        exp_t e;
        if (sync) @(negedge clk);
        start = 1'b1;
        aluop = op;
        in1   = a;
        in2   = b;
        if (expect_result) begin
            e       = model(op, a, b);
            e.tag   = tag;
            e.issue = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic waitDone(input int bound);
        bit got;
        got = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) checkOutput("wait_done_timeout", {63'b0, done}, 64'd1);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest request
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", {63'b0, done}, 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput({e.tag, "_out"}, 64'(out), 64'(e.out));
                checkOutput({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
                checkOutput({e.tag, "_zf"}, 64'(zeroflag), 64'(e.zf));
                checkOutput({e.tag, "_dz"}, 64'(divzero), 64'(e.dz));
                checkOutput({e.tag, "_latency"}, 64'(cyc - e.issue), 64'(e.lat));
            end
        end
    end

    initial begin
        int bc;
        bit got;
        logic [W-1:0] ra, rb;

        reset = 1'b1;
        start = 1'b0;
        aluop = '0;
        in1   = '0;
        in2   = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_out", 64'(out), 64'd0);
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_zf", 64'(zeroflag), 64'd0);
        checkOutput("reset_dz", 64'(divzero), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        reset = 1'b0;

        // Back-to-back single-cycle ops, one per cycle
        applyStimulus(ALU_ADD,  32'd10, 32'd5, "add", 1, 1);
        applyStimulus(ALU_SUB,  32'd10, 32'd5, "sub", 1, 1);
        applyStimulus(ALU_SLT,  32'hFFFF_FFFF, 32'd1, "slt", 1, 1);
        applyStimulus(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, "sltu", 1, 1);
        applyStimulus(ALU_SRL,  32'd1, 32'd5, "srl", 1, 1);
        applyStimulus(ALU_SLL,  32'd1, 32'd36, "sll", 1, 1);
        applyStimulus(ALU_AND,  32'h0000_F0F0, 32'h0000_FF00, "and", 1, 1);
        applyStimulus(ALU_OR,   32'h0000_F0F0, 32'h0000_FF00, "or", 1, 1);
        applyStimulus(ALU_NOR,  32'h0000_F0F0, 32'h0000_FF00, "nor", 1, 1);
        applyStimulus(ALU_ADD,  32'hFFFF_FFFF, 32'd1, "add_wrap", 1, 1);
        applyStimulus(ALU_SUB,  32'h1234_5678, 32'h1234_5678, "sub_eq", 1, 1);
        applyStimulus(ALU_SRL,  32'h8000_0000, 32'd31, "srl_max", 1, 1);
        applyStimulus(4'd12,    32'd3, 32'd4, "illegal", 1, 1);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // multu with a mid-run start and operand change that must be ignored
        applyStimulus(ALU_MULTU, 32'hFFFF_FFFF, 32'd2, "multu", 1, 1);
        bc  = 0;
        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            start = (n == 5);
            if (n == 5) begin
                aluop = ALU_ADD;
                in1   = 32'd7;
                in2   = 32'd7;
            end else if (n == 6) begin
                aluop = ALU_SUB;
                in1   = 32'd123;
                in2   = 32'd456;
            end
            if (busy) bc++;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) checkOutput("multu_timeout", {63'b0, done}, 64'd1);
        checkOutput("multu_busy_cycles", 64'(bc), 64'd32);
        // Issue in the done cycle itself: must be accepted immediately
        applyStimulus(ALU_ADD, 32'd3, 32'd4, "add_b2b", 0, 1);
        @(negedge clk);
        start = 1'b0;

        applyStimulus(ALU_DIVU, 32'd100, 32'd7, "divu", 1, 1);
        @(negedge clk);
        start = 1'b0;
        waitDone(40);

        applyStimulus(ALU_DIVU, 32'd9, 32'd0, "divu_zero", 1, 1);
        @(negedge clk);
        start = 1'b0;
        waitDone(40);

        ra = $urandom;
        rb = $urandom;
        applyStimulus(ALU_MULTU, ra, rb, "multu_rand", 1, 1);
        @(negedge clk);
        start = 1'b0;
        waitDone(40);

        rb = $urandom_range(1, 65535);
        applyStimulus(ALU_DIVU, ra, rb, "divu_rand", 1, 1);
        @(negedge clk);
        start = 1'b0;
        waitDone(40);

        // Reset ten cycles into a divide: outputs clear and no done follows
        applyStimulus(ALU_DIVU, 32'd1000, 32'd3, "divu_abort", 1, 0);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_out", 64'(out), 64'd0);
        checkOutput("abort_hi", 64'(hi), 64'd0);
        checkOutput("abort_zf", 64'(zeroflag), 64'd0);
        checkOutput("abort_dz", 64'(divzero), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("abort_idle_busy", 64'(busy), 64'd0);

        // Reset and start together: reset wins
        reset = 1'b1;
        applyStimulus(ALU_ADD, 32'd1, 32'd1, "rst_start", 0, 0);
        @(negedge clk);
        checkOutput("rst_start_done", 64'(done), 64'd0);
        checkOutput("rst_start_zf", 64'(zeroflag), 64'd0);
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
